// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM block: register map, CTRL bit
// positions, AXI response encoding and small address/strobe helpers.
package pwm_multi_pkg;

    // Register byte offsets
    localparam int unsigned OfsCtrl   = 32'h00;
    localparam int unsigned OfsPeriod = 32'h04;
    localparam int unsigned OfsCount  = 32'h08;
    localparam int unsigned OfsRsvd   = 32'h0C;
    localparam int unsigned OfsDuty0  = 32'h10;

    // CTRL bit positions
    localparam int unsigned CtrlEnBit = 0;
    localparam int unsigned CtrlChLsb = 8;

    // AXI response encoding
    localparam logic [1:0] RespOkay = 2'b00;

    typedef enum logic [2:0] {
        RegCtrl,
        RegPeriod,
        RegCount,
        RegDuty,
        RegNone
    } reg_sel_e;

    // Map a byte address onto a register class; reserved and unmapped both give RegNone.
    function automatic reg_sel_e decode_addr(input int unsigned byte_addr,
                                             input int unsigned num_ch);
        int unsigned ofs;
        ofs = byte_addr & ~32'h3;
        if (ofs == OfsCtrl) begin
            return RegCtrl;
        end else if (ofs == OfsPeriod) begin
            return RegPeriod;
        end else if (ofs == OfsCount) begin
            return RegCount;
        end else if (ofs == OfsRsvd) begin
            return RegNone;
        end else if (ofs >= OfsDuty0 && ofs < OfsDuty0 + 4 * num_ch) begin
            return RegDuty;
        end
        return RegNone;
    endfunction

    // Channel number addressed by a DUTY byte address.
    function automatic int unsigned duty_index(input int unsigned byte_addr);
        return (byte_addr - OfsDuty0) >> 2;
    endfunction

    // Merge write data into an existing word honouring byte strobes.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_multi_regs.sv
// AXI4-Lite slave and register bank for the multi-channel PWM: handshakes,
// CTRL, and the PERIOD/DUTY shadow registers.
module pwm_multi_regs
    import pwm_multi_pkg::*;
#(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned CNT_W              = 16,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [CNT_W-1:0]                  count_i,
    output logic                              en_o,
    output logic [NUM_CH-1:0]                 ch_en_o,
    output logic [CNT_W-1:0]                  period_o,
    output logic [NUM_CH*CNT_W-1:0]           duty_o
);

    // live_q keeps the readies low while reset is asserted and for the first cycle after.
    logic                          live_q;
    logic                          bvalid_q;
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic                          en_q;
    logic [NUM_CH-1:0]             ch_en_q;
    logic [CNT_W-1:0]              period_q;
    logic [CNT_W-1:0]              duty_q [NUM_CH];

    logic        wr_accept;
    logic        rd_accept;
    logic [31:0] wr_addr;
    logic [31:0] rd_addr;
    logic [31:0] wr_merged;
    reg_sel_e    wr_sel;

    // Current readable value of the register at a byte address (0 when unmapped).
    function automatic logic [31:0] reg_word(input int unsigned byte_addr);
        logic [31:0] w;
        w = '0;
        case (decode_addr(byte_addr, NUM_CH))
            RegCtrl: begin
                w[CtrlEnBit]           = en_q;
                w[CtrlChLsb +: NUM_CH] = ch_en_q;
            end
            RegPeriod: w[CNT_W-1:0] = period_q;
            RegCount:  w[CNT_W-1:0] = count_i;
            RegDuty: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (duty_index(byte_addr) == i) begin
                        w[CNT_W-1:0] = duty_q[i];
                    end
                end
            end
            default: ;
        endcase
        return w;
    endfunction

    assign wr_addr   = 32'(S_AXI_AWADDR);
    assign rd_addr   = 32'(S_AXI_ARADDR);
    assign wr_accept = live_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
    assign rd_accept = live_q && S_AXI_ARVALID && !rvalid_q;

    // Decode the write target and merge the strobed bytes into its current value
    always_comb begin
        wr_sel    = decode_addr(wr_addr, NUM_CH);
        wr_merged = apply_wstrb(reg_word(wr_addr), S_AXI_WDATA, S_AXI_WSTRB);
    end

    // AXI handshake state: response valids and captured read data
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            live_q   <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            live_q <= 1'b1;
            if (wr_accept) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            // Read data is captured before any same-cycle write lands
            if (rd_accept) begin
                rvalid_q <= 1'b1;
                rdata_q  <= reg_word(rd_addr);
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register bank updates on an accepted write; COUNT and unmapped targets are dropped
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            en_q     <= 1'b0;
            ch_en_q  <= '0;
            period_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
            end
        end else if (wr_accept) begin
            case (wr_sel)
                RegCtrl: begin
                    en_q    <= wr_merged[CtrlEnBit];
                    ch_en_q <= wr_merged[CtrlChLsb +: NUM_CH];
                end
                RegPeriod: period_q <= wr_merged[CNT_W-1:0];
                RegDuty: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (duty_index(wr_addr) == i) begin
                            duty_q[i] <= wr_merged[CNT_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_duty_out
        assign duty_o[g*CNT_W +: CNT_W] = duty_q[g];
    end

    assign S_AXI_AWREADY = wr_accept;
    assign S_AXI_WREADY  = wr_accept;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RespOkay;
    assign S_AXI_ARREADY = rd_accept;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RespOkay;
    assign en_o          = en_q;
    assign ch_en_o       = ch_en_q;
    assign period_o      = period_q;

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_merged};

endmodule

// File: rtl/pwm_multi_axi.sv
// Multi-channel PWM generator with an AXI4-Lite register interface. The free
// running counter and compare logic live here; the bus side is pwm_multi_regs.
module pwm_multi_axi
    import pwm_multi_pkg::*;
#(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned CNT_W              = 16,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_CH-1:0]                 pwm_out
);

    logic                    en;
    logic [NUM_CH-1:0]       ch_en;
    logic [CNT_W-1:0]        period_sh;
    logic [NUM_CH*CNT_W-1:0] duty_sh;

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  period_act_q;
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;

    pwm_multi_regs #(
        .NUM_CH             (NUM_CH),
        .CNT_W              (CNT_W),
        .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
    ) u_regs (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .count_i       (count_q),
        .en_o          (en),
        .ch_en_o       (ch_en),
        .period_o      (period_sh),
        .duty_o        (duty_sh)
    );

    // Counter, double-buffered period/duty and registered compare outputs.
    // Actives follow the shadows while disabled and reload only at wrap while running,
    // so a period never sees a half-updated configuration.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            count_q      <= '0;
            period_act_q <= '0;
            pwm_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act_q[i] <= '0;
            end
        end else if (!en) begin
            count_q      <= '0;
            period_act_q <= period_sh;
            pwm_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act_q[i] <= duty_sh[i*CNT_W +: CNT_W];
            end
        end else begin
            if (count_q >= period_act_q) begin
                count_q      <= '0;
                period_act_q <= period_sh;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_q[i] <= duty_sh[i*CNT_W +: CNT_W];
                end
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
            // Channel enables gate directly so they act on the next cycle
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_q[i] <= ch_en[i] && (count_q < duty_act_q[i]);
            end
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_multi_axi.sv
// Self-checking bench for pwm_multi_axi: AXI transactions push expected
// responses into queues, a monitor pops and compares on each handshake.
module tb_pwm_multi_axi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int AW     = 6;

    logic              tb_ACLK;
    logic              tb_ARESETN;
    logic [AW-1:0]     s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [AW-1:0]     s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [NUM_CH-1:0] pwm_out;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } rd_exp_t;

    rd_exp_t    exp_r_q[$];
    logic [1:0] exp_b_q[$];
    rd_exp_t    mon_r;
    logic [1:0] mon_b;
    int         n_checks = 0;
    int         n_fail   = 0;

    pwm_multi_axi #(
        .NUM_CH             (NUM_CH),
        .CNT_W              (CNT_W),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESETN (tb_ARESETN),
        .S_AXI_AWADDR  (s_axi_awaddr),
        .S_AXI_AWPROT  (s_axi_awprot),
        .S_AXI_AWVALID (s_axi_awvalid),
        .S_AXI_AWREADY (s_axi_awready),
        .S_AXI_WDATA   (s_axi_wdata),
        .S_AXI_WSTRB   (s_axi_wstrb),
        .S_AXI_WVALID  (s_axi_wvalid),
        .S_AXI_WREADY  (s_axi_wready),
        .S_AXI_BRESP   (s_axi_bresp),
        .S_AXI_BVALID  (s_axi_bvalid),
        .S_AXI_BREADY  (s_axi_bready),
        .S_AXI_ARADDR  (s_axi_araddr),
        .S_AXI_ARPROT  (s_axi_arprot),
        .S_AXI_ARVALID (s_axi_arvalid),
        .S_AXI_ARREADY (s_axi_arready),
        .S_AXI_RDATA   (s_axi_rdata),
        .S_AXI_RRESP   (s_axi_rresp),
        .S_AXI_RVALID  (s_axi_rvalid),
        .S_AXI_RREADY  (s_axi_rready),
        .pwm_out       (pwm_out)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, required event within bound", name);
    endtask

    // Monitor: compare every completed read/write response with the scoreboard
    always @(negedge tb_ACLK) begin
        if (tb_ARESETN) begin
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_r: got read data 0x%08h, required no response",
                             s_axi_rdata);
                end else begin
                    mon_r = exp_r_q.pop_front();
                    check($sformatf("rdata@0x%02h", mon_r.addr), s_axi_rdata, mon_r.data);
                    check("rresp", 32'(s_axi_rresp), 32'd0);
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_b: got bresp %0d, required no response", s_axi_bresp);
                end else begin
                    mon_b = exp_b_q.pop_front();
                    check("bresp", 32'(s_axi_bresp), 32'(mon_b));
                end
            end
        end
    end

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit wait_resp);
        int t;
        exp_b_q.push_back(2'b00);
        @(posedge tb_ACLK);
        #1;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        t = 0;
        @(negedge tb_ACLK);
        while (!(s_axi_awready && s_axi_wready) && t < 50) begin
            @(negedge tb_ACLK);
            t++;
        end
        if (!(s_axi_awready && s_axi_wready)) timeout("aw_w_handshake");
        @(posedge tb_ACLK);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (wait_resp) begin
            t = 0;
            @(negedge tb_ACLK);
            while (!s_axi_bvalid && t < 50) begin
                @(negedge tb_ACLK);
                t++;
            end
            if (!s_axi_bvalid) timeout("b_wait");
            @(posedge tb_ACLK);
            #1;
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp,
                            input bit wait_resp);
        int t;
        exp_r_q.push_back('{addr: addr, data: exp});
        @(posedge tb_ACLK);
        #1;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        t = 0;
        @(negedge tb_ACLK);
        while (!s_axi_arready && t < 50) begin
            @(negedge tb_ACLK);
            t++;
        end
        if (!s_axi_arready) timeout("ar_handshake");
        @(posedge tb_ACLK);
        #1;
        s_axi_arvalid = 1'b0;
        if (wait_resp) begin
            t = 0;
            @(negedge tb_ACLK);
            while (!s_axi_rvalid && t < 50) begin
                @(negedge tb_ACLK);
                t++;
            end
            if (!s_axi_rvalid) timeout("r_wait");
            @(posedge tb_ACLK);
            #1;
        end
    endtask

    // Returns at the negedge where pwm_out[0] has just gone high
    task automatic wait_rise();
        logic prev;
        bit   found;
        int   t;
        prev  = pwm_out[0];
        found = 1'b0;
        t     = 0;
        while (!found && t < 100) begin
            @(negedge tb_ACLK);
            if (pwm_out[0] && !prev) found = 1'b1;
            prev = pwm_out[0];
            t++;
        end
        if (!found) timeout("pwm_rise");
    endtask

    // Period 10 pattern from the rising edge: bit0 high for the first 'duty' cycles
    task automatic check_pwm(input string tag, input int duty, input logic [3:0] mask,
                             input logic [3:0] hi_exp, input int n);
        logic [3:0] e;
        for (int k = 0; k < n; k++) begin
            e = hi_exp;
            if (mask[0]) e[0] = ((k % 10) < duty);
            check($sformatf("%s_cyc%0d", tag, k), 32'(pwm_out & mask), 32'(e & mask));
            @(negedge tb_ACLK);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev;
        bit   found;
        int   highs;
        int   t;

        tb_ARESETN    = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awprot  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arprot  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        #2;
        tb_ARESETN = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        @(posedge tb_ACLK);
        #1;
        tb_ARESETN = 1'b1;

        // All registers read zero after reset
        for (int a = 0; a < 8; a++) axi_read(AW'(4 * a), 32'd0, 1'b1);

        // Strobed PERIOD write, COUNT/reserved/unmapped writes ignored, CTRL masking
        axi_write(6'h04, 32'h0000_FFFF, 4'b0001, 1'b1);
        axi_read(6'h04, 32'h0000_00FF, 1'b1);
        axi_write(6'h08, 32'h0000_1234, 4'hF, 1'b1);
        axi_read(6'h08, 32'd0, 1'b1);
        axi_write(6'h0C, 32'hDEAD_BEEF, 4'hF, 1'b1);
        axi_read(6'h0C, 32'd0, 1'b1);
        axi_write(6'h20, 32'hDEAD_BEEF, 4'hF, 1'b1);
        axi_read(6'h20, 32'd0, 1'b1);
        axi_write(6'h10, 32'hABCD_5678, 4'hF, 1'b1);
        axi_read(6'h10, 32'h0000_5678, 1'b1);
        axi_write(6'h00, 32'hFFFF_FFFF, 4'hF, 1'b1);
        axi_read(6'h00, 32'h0000_0F01, 1'b1);
        axi_write(6'h00, 32'd0, 4'hF, 1'b1);
        axi_read(6'h00, 32'd0, 1'b1);

        // Basic PWM: period 10, duty 3 on channel 0 only
        axi_write(6'h04, 32'd9, 4'hF, 1'b1);
        axi_write(6'h10, 32'd3, 4'hF, 1'b1);
        axi_write(6'h00, 32'h0000_0101, 4'hF, 1'b1);
        wait_rise();
        check_pwm("duty3", 3, 4'b1111, 4'b0000, 20);

        // Duty change mid-period only takes effect at the next wrap
        wait_rise();
        repeat (3) @(negedge tb_ACLK);
        axi_write(6'h10, 32'd7, 4'hF, 1'b1);
        highs = int'(pwm_out[0]);
        prev  = pwm_out[0];
        found = 1'b0;
        t     = 0;
        while (!found && t < 30) begin
            @(negedge tb_ACLK);
            if (pwm_out[0] && !prev) found = 1'b1;
            else if (pwm_out[0]) highs++;
            prev = pwm_out[0];
            t++;
        end
        if (!found) timeout("pwm_rise_after_duty_write");
        check("old_duty_until_wrap", 32'(highs), 32'd0);
        check_pwm("duty7", 7, 4'b1111, 4'b0000, 20);
        axi_read(6'h10, 32'd7, 1'b1);

        // Boundary duties: 0 -> low, above period -> high
        axi_write(6'h14, 32'd0, 4'hF, 1'b1);
        axi_write(6'h18, 32'd20, 4'hF, 1'b1);
        axi_write(6'h1C, 32'h0000_FFFF, 4'hF, 1'b1);
        axi_write(6'h00, 32'h0000_0F01, 4'hF, 1'b1);
        repeat (12) @(negedge tb_ACLK);
        check_pwm("edge_duty", 0, 4'b1110, 4'b1100, 20);

        // Back-pressure: responses held, no second write accepted
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        axi_write(6'h14, 32'd5, 4'hF, 1'b0);
        axi_read(6'h04, 32'd9, 1'b0);
        s_axi_awaddr  = 6'h18;
        s_axi_wdata   = 32'h55;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge tb_ACLK);
            check($sformatf("hold_bvalid%0d", k), 32'(s_axi_bvalid), 32'd1);
            check($sformatf("hold_rvalid%0d", k), 32'(s_axi_rvalid), 32'd1);
            check($sformatf("hold_rdata%0d", k), s_axi_rdata, 32'd9);
            check($sformatf("hold_awready%0d", k), 32'(s_axi_awready), 32'd0);
        end

        // Asynchronous reset in the middle of the held responses
        @(posedge tb_ACLK);
        #3;
        tb_ARESETN = 1'b0;
        #1;
        check("arst_awready", 32'(s_axi_awready), 32'd0);
        check("arst_wready", 32'(s_axi_wready), 32'd0);
        check("arst_arready", 32'(s_axi_arready), 32'd0);
        check("arst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("arst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("arst_rdata", s_axi_rdata, 32'd0);
        check("arst_resp", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        check("arst_pwm", 32'(pwm_out), 32'd0);
        exp_b_q.delete();
        exp_r_q.delete();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_rready  = 1'b1;
        repeat (2) @(posedge tb_ACLK);
        #1;
        tb_ARESETN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge tb_ACLK);
            check($sformatf("post_rst_resp%0d", k), 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
        end
        axi_read(6'h00, 32'd0, 1'b1);
        axi_read(6'h18, 32'd0, 1'b1);
        axi_read(6'h04, 32'd0, 1'b1);
        check("post_rst_pwm", 32'(pwm_out), 32'd0);

        repeat (2) @(negedge tb_ACLK);
        check("scoreboard_drained", 32'(exp_r_q.size() + exp_b_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
